// File: rtl/tx_interp_chain_pkg.sv
// Shared widths, the I/Q sample record and the rate-counter reload helper
// for the TX interpolation chain.
package tx_interp_chain_pkg;

  localparam int SAMPLE_W = 16;
  localparam int PHASE_W  = 32;
  localparam int RATE_W   = 8;
  localparam int ADDR_W   = 7;

  typedef struct packed {
    logic [SAMPLE_W-1:0] i;
    logic [SAMPLE_W-1:0] q;
  } iq_t;

  // A ratio of 0 behaves as 1, so both reload the counter with 0.
  function automatic logic [RATE_W-1:0] reload_count(input logic [RATE_W-1:0] rate);
    return (rate == '0) ? '0 : rate - 1'b1;
  endfunction

endpackage

// File: rtl/tx_interp_chain_phase_acc.sv
// NCO phase accumulator with serially loaded frequency and phase words.
// A direct phase load always beats the accumulate step in the same cycle.
module tx_interp_chain_phase_acc
  import tx_interp_chain_pkg::*;
#(
  parameter logic [ADDR_W-1:0] FREQADDR  = '0,
  parameter logic [ADDR_W-1:0] PHASEADDR = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               tick,
  input  logic [ADDR_W-1:0]  serial_addr,
  input  logic [PHASE_W-1:0] serial_data,
  input  logic               serial_strobe,
  output logic [PHASE_W-1:0] phase
);

  logic [PHASE_W-1:0] freq_reg;
  logic [PHASE_W-1:0] phase_reg;

  logic freq_wr;
  logic phase_wr;

  assign freq_wr  = serial_strobe && (serial_addr == FREQADDR);
  assign phase_wr = serial_strobe && (serial_addr == PHASEADDR);

  // Frequency word: only reset or a serial write changes it; survives enable low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        freq_reg <= '0;
    else if (freq_wr) freq_reg <= serial_data;
  end

  // Phase: direct load first, then flush while disabled, else advance once per DAC tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         phase_reg <= '0;
    else if (phase_wr) phase_reg <= serial_data;
    else if (!enable)  phase_reg <= '0;
    else if (tick)     phase_reg <= phase_reg + freq_reg;
  end

  assign phase = phase_reg;

endmodule

// File: rtl/tx_interp_chain.sv
// TX interpolation chain: pulls one I/Q pair from the TX FIFO every R DAC ticks,
// holds it at DAC rate (zero-order hold), flags underrun and drives the NCO phase.
module tx_interp_chain
  import tx_interp_chain_pkg::*;
#(
  parameter logic [ADDR_W-1:0] FREQADDR  = '0,
  parameter logic [ADDR_W-1:0] PHASEADDR = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [RATE_W-1:0]   interp_rate,
  input  logic                sample_strobe,
  output logic                interpolator_strobe,
  input  logic                data_valid,
  input  logic [ADDR_W-1:0]   serial_addr,
  input  logic [PHASE_W-1:0]  serial_data,
  input  logic                serial_strobe,
  input  logic [SAMPLE_W-1:0] i_in,
  input  logic [SAMPLE_W-1:0] q_in,
  output logic [SAMPLE_W-1:0] i_out,
  output logic [SAMPLE_W-1:0] q_out,
  output logic [PHASE_W-1:0]  phase,
  output logic                underrun
);

  logic [RATE_W-1:0] count_reg;
  iq_t               hold_reg;
  logic              underrun_reg;
  logic              tick;
  logic              fire;

  assign tick = enable & sample_strobe;
  assign fire = tick & (count_reg == '0);

  // The request pulse is suppressed while reset is held so nothing is consumed then.
  assign interpolator_strobe = fire & ~reset;

  // Rate counter: reload on a request, count down on other DAC ticks, park at 0 when idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        count_reg <= '0;
    else if (!enable) count_reg <= '0;
    else if (fire)    count_reg <= reload_count(interp_rate);
    else if (tick)    count_reg <= count_reg - 1'b1;
  end

  // Hold registers: capture the FIFO word on a request, zero-fill when it was empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)             hold_reg <= '0;
    else if (!enable)      hold_reg <= '0;
    else if (fire) begin
      if (data_valid) hold_reg <= '{i: i_in, q: q_in};
      else            hold_reg <= '0;
    end
  end

  // Sticky underrun: set by a request that found no data, cleared only by disabling.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                    underrun_reg <= 1'b0;
    else if (!enable)             underrun_reg <= 1'b0;
    else if (fire && !data_valid) underrun_reg <= 1'b1;
  end

  assign i_out    = hold_reg.i;
  assign q_out    = hold_reg.q;
  assign underrun = underrun_reg;

  tx_interp_chain_phase_acc #(
    .FREQADDR  (FREQADDR),
    .PHASEADDR (PHASEADDR)
  ) u_phase_acc (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .tick          (tick),
    .serial_addr   (serial_addr),
    .serial_data   (serial_data),
    .serial_strobe (serial_strobe),
    .phase         (phase)
  );

endmodule
